// File: rtl/adder_result_checker.sv
// Response checker for the adder harness: compares DUT results against a
// latency-matched reference sum and reports per-run pass/fail.
module adder_result_checker #(
    parameter int WIDTH      = 4,
    parameter int LATENCY    = 0,
    parameter int NUM_CHECKS = 80,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] check_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic [WIDTH-1:0] first_err_q
);

    if (NUM_CHECKS < 1 || NUM_CHECKS > (2 ** CNT_W) - 1) begin : g_bad_num
        $error("NUM_CHECKS must be in 1..2**CNT_W-1");
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_lat
        $error("LATENCY must be in 0..15");
    end

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHECKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] chk_q, chk_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fev_q, fev_d;
    logic [WIDTH-1:0] fa_q, fa_d;
    logic [WIDTH-1:0] fb_q, fb_d;
    logic [WIDTH-1:0] fq_q, fq_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             in_v;
    logic             flush;
    logic [WIDTH-1:0] exp_sum;
    logic             cmp_v;
    logic [WIDTH-1:0] cmp_a, cmp_b, cmp_e;
    logic             mism;

    assign in_v    = in_valid && (state_q == S_RUN);
    assign flush   = start && (state_q != S_RUN);
    assign exp_sum = a + b;

    if (LATENCY == 0) begin : g_nodly
        assign cmp_v = in_v;
        assign cmp_a = a;
        assign cmp_b = b;
        assign cmp_e = exp_sum;
    end else begin : g_dly
        logic [LATENCY-1:0] v_q;
        logic [WIDTH-1:0]   a_q [LATENCY];
        logic [WIDTH-1:0]   b_q [LATENCY];
        logic [WIDTH-1:0]   e_q [LATENCY];

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                v_q <= '0;
            end else begin
                v_q[0] <= in_v;
                for (int i = 1; i < LATENCY; i++) begin
                    v_q[i] <= v_q[i-1];
                end
            end
        end

        // Payload needs no reset: it is only consumed alongside v_q.
        always_ff @(posedge clk) begin
            a_q[0] <= a;
            b_q[0] <= b;
            e_q[0] <= exp_sum;
            for (int i = 1; i < LATENCY; i++) begin
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
                e_q[i] <= e_q[i-1];
            end
        end

        assign cmp_v = v_q[LATENCY-1];
        assign cmp_a = a_q[LATENCY-1];
        assign cmp_b = b_q[LATENCY-1];
        assign cmp_e = e_q[LATENCY-1];
    end

    assign mism = cmp_v && (q != cmp_e);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == '1) ? x : x + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        chk_d   = chk_q;
        err_d   = err_q;
        fev_d   = fev_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        fq_d    = fq_q;
        done_d  = done_q;
        pass_d  = pass_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    chk_d   = '0;
                    err_d   = '0;
                    fev_d   = 1'b0;
                    fa_d    = '0;
                    fb_d    = '0;
                    fq_d    = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (cmp_v) begin
                    chk_d = sat_inc(chk_q);
                    if (mism) begin
                        err_d = sat_inc(err_q);
                        if (!fev_q) begin
                            fev_d = 1'b1;
                            fa_d  = cmp_a;
                            fb_d  = cmp_b;
                            fq_d  = q;
                        end
                    end
                    if (chk_q == LAST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            chk_q   <= '0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fa_q    <= '0;
            fb_q    <= '0;
            fq_q    <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chk_q   <= chk_d;
            err_q   <= err_d;
            fev_q   <= fev_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            fq_q    <= fq_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign busy            = (state_q == S_RUN);
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign check_count     = chk_q;
    assign first_err_valid = fev_q;
    assign first_err_a     = fa_q;
    assign first_err_b     = fb_q;
    assign first_err_q     = fq_q;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: default, latency-matched,
// latency-mismatched and narrow-counter configurations.
module tb_adder_result_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, inv;
    logic       st0, stl, st7;
    logic [3:0] ina, inb, inq;
    int         npass = 0;
    int         ntot  = 0;

    logic       busy0, done0, pass0, fev0;
    logic [7:0] err0, cnt0;
    logic [3:0] fa0, fb0, fq0;
    logic       busy2, done2, pass2, fev2;
    logic [7:0] err2, cnt2;
    logic [3:0] fa2, fb2, fq2;
    logic       busy1, done1, pass1, fev1;
    logic [7:0] err1, cnt1;
    logic [3:0] fa1, fb1, fq1;
    logic       busy7, done7, pass7, fev7;
    logic [1:0] err7, cnt7;
    logic [3:0] fa7, fb7, fq7;

    adder_result_checker u0 (
        .clk(clk), .rst(rst), .start(st0), .in_valid(inv),
        .a(ina), .b(inb), .q(inq),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .check_count(cnt0),
        .first_err_valid(fev0), .first_err_a(fa0),
        .first_err_b(fb0), .first_err_q(fq0)
    );

    adder_result_checker #(.LATENCY(2), .NUM_CHECKS(8)) u2 (
        .clk(clk), .rst(rst), .start(stl), .in_valid(inv),
        .a(ina), .b(inb), .q(inq),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .check_count(cnt2),
        .first_err_valid(fev2), .first_err_a(fa2),
        .first_err_b(fb2), .first_err_q(fq2)
    );

    adder_result_checker #(.LATENCY(1), .NUM_CHECKS(8)) u1 (
        .clk(clk), .rst(rst), .start(stl), .in_valid(inv),
        .a(ina), .b(inb), .q(inq),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .check_count(cnt1),
        .first_err_valid(fev1), .first_err_a(fa1),
        .first_err_b(fb1), .first_err_q(fq1)
    );

    adder_result_checker #(.CNT_W(2), .NUM_CHECKS(3)) u7 (
        .clk(clk), .rst(rst), .start(st7), .in_valid(inv),
        .a(ina), .b(inb), .q(inq),
        .busy(busy7), .done(done7), .pass(pass7),
        .err_count(err7), .check_count(cnt7),
        .first_err_valid(fev7), .first_err_a(fa7),
        .first_err_b(fb7), .first_err_q(fq7)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        int         err;
    } vrec_t;

    vrec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic vec(input logic [3:0] va, input logic [3:0] vb,
                       input logic [3:0] vq);
        inv = 1'b1;
        ina = va;
        inb = vb;
        inq = vq;
        tick();
        inv = 1'b0;
    endtask

    task automatic good(input int i);
        logic [3:0] va, vb, vq;
        va = 4'(i % 16);
        vb = 4'((i / 10) % 16);
        vq = va + vb;
        vec(va, vb, vq);
    endtask

    logic [15:0] pat;
    logic [3:0]  sa [16];
    logic [3:0]  sb [16];
    logic [3:0]  ss [16];

    initial begin
        rst = 1'b1; inv = 1'b0;
        st0 = 1'b0; stl = 1'b0; st7 = 1'b0;
        ina = '0; inb = '0; inq = '0;
        tbl[0] = '{4'd5,  4'd7,  4'd11, 1};
        tbl[1] = '{4'd15, 4'd1,  4'd0,  1};
        tbl[2] = '{4'd15, 4'd15, 4'd14, 1};
        tbl[3] = '{4'd0,  4'd0,  4'd0,  1};
        tbl[4] = '{4'd8,  4'd8,  4'd0,  1};
        tbl[5] = '{4'd3,  4'd3,  4'd5,  2};
        tbl[6] = '{4'd15, 4'd0,  4'd15, 2};
        tbl[7] = '{4'd9,  4'd9,  4'd2,  2};

        // Reset
        tick(); tick();
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_fev", 32'(fev0), 0);
        chk("rst_busy7", 32'(busy7), 0);
        rst = 1'b0;
        tick();

        // Full correct run; start mid-run must be ignored
        st0 = 1'b1; tick(); st0 = 1'b0;
        chk("t2_busy_start", 32'(busy0), 1);
        for (int i = 0; i < 80; i++) begin
            if (i == 40) st0 = 1'b1;
            good(i);
            st0 = 1'b0;
            if (i == 78) begin
                chk("t2_cnt79", 32'(cnt0), 79);
                chk("t2_done79", 32'(done0), 0);
                chk("t2_busy79", 32'(busy0), 1);
            end
        end
        chk("t2_done", 32'(done0), 1);
        chk("t2_busy", 32'(busy0), 0);
        chk("t2_cnt", 32'(cnt0), 80);
        chk("t2_err", 32'(err0), 0);
        chk("t2_pass", 32'(pass0), 1);
        chk("t2_fev", 32'(fev0), 0);
        vec(4'd1, 4'd1, 4'd0);
        vec(4'd2, 4'd2, 4'd0);
        chk("done_ign_cnt", 32'(cnt0), 80);
        chk("done_ign_err", 32'(err0), 0);

        // Mismatch and wrap vectors
        st0 = 1'b1; tick(); st0 = 1'b0;
        chk("t3_clr_done", 32'(done0), 0);
        chk("t3_clr_cnt", 32'(cnt0), 0);
        chk("t3_clr_pass", 32'(pass0), 0);
        for (int i = 0; i < 8; i++) begin
            vec(tbl[i].a, tbl[i].b, tbl[i].q);
            chk($sformatf("tbl_err[%0d]", i), 32'(err0), 32'(tbl[i].err));
        end
        chk("t3_fev", 32'(fev0), 1);
        chk("t3_fa", 32'(fa0), 5);
        chk("t3_fb", 32'(fb0), 7);
        chk("t3_fq", 32'(fq0), 11);
        for (int i = 0; i < 72; i++) good(i);
        chk("t3_done", 32'(done0), 1);
        chk("t3_cnt", 32'(cnt0), 80);
        chk("t3_err", 32'(err0), 2);
        chk("t3_pass", 32'(pass0), 0);

        // Reset mid-run
        st0 = 1'b1; tick(); st0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3 || i == 10 || i == 20)
                vec(4'(i % 16), 4'(i / 10), 4'((i % 16) + (i / 10) + 1));
            else
                good(i);
        end
        chk("t6_cnt40", 32'(cnt0), 40);
        chk("t6_err3", 32'(err0), 3);
        rst = 1'b1; st0 = 1'b1; tick(); rst = 1'b0; st0 = 1'b0;
        chk("t6_busy", 32'(busy0), 0);
        chk("t6_done", 32'(done0), 0);
        chk("t6_err", 32'(err0), 0);
        chk("t6_cnt", 32'(cnt0), 0);
        chk("t6_fev", 32'(fev0), 0);
        vec(4'd1, 4'd2, 4'd0);
        vec(4'd3, 4'd4, 4'd0);
        chk("t6_ign_cnt", 32'(cnt0), 0);
        chk("t6_ign_err", 32'(err0), 0);
        st0 = 1'b1; tick(); st0 = 1'b0;
        for (int i = 0; i < 80; i++) good(i);
        chk("t6_re_done", 32'(done0), 1);
        chk("t6_re_pass", 32'(pass0), 1);
        chk("t6_re_err", 32'(err0), 0);

        // Latency-2 stream with gaps, DUT model delays q by 2 cycles
        pat = 16'b0000_1101_1100_1101;
        begin
            int n;
            n = 0;
            for (int k = 0; k < 16; k++) begin
                sa[k] = '0; sb[k] = '0; ss[k] = '0;
                if (pat[k]) begin
                    sa[k] = 4'(n + 1);
                    sb[k] = 4'(n);
                    ss[k] = 4'(2 * n + 1);
                    n++;
                end
            end
        end
        stl = 1'b1; tick(); stl = 1'b0;
        for (int k = 0; k < 16; k++) begin
            inv = pat[k];
            ina = sa[k];
            inb = sb[k];
            inq = (k >= 2 && pat[k-2]) ? ss[k-2] : 4'd0;
            tick();
        end
        inv = 1'b0;
        chk("t5_l2_done", 32'(done2), 1);
        chk("t5_l2_cnt", 32'(cnt2), 8);
        chk("t5_l2_err", 32'(err2), 0);
        chk("t5_l2_pass", 32'(pass2), 1);
        chk("t5_l1_done", 32'(done1), 1);
        chk("t5_l1_err", 32'(err1), 8);
        chk("t5_l1_pass", 32'(pass1), 0);
        chk("t5_l1_fa", 32'(fa1), 1);
        chk("t5_l1_fb", 32'(fb1), 0);
        chk("t5_l1_fq", 32'(fq1), 0);

        // Narrow counters, every result wrong
        st7 = 1'b1; tick(); st7 = 1'b0;
        vec(4'd1, 4'd1, 4'd0);
        chk("t7_err1", 32'(err7), 1);
        vec(4'd2, 4'd2, 4'd0);
        chk("t7_err2", 32'(err7), 2);
        chk("t7_done2", 32'(done7), 0);
        vec(4'd3, 4'd3, 4'd0);
        chk("t7_err3", 32'(err7), 3);
        chk("t7_cnt3", 32'(cnt7), 3);
        chk("t7_done", 32'(done7), 1);
        chk("t7_pass", 32'(pass7), 0);
        vec(4'd4, 4'd4, 4'd0);
        chk("t7_err_hold", 32'(err7), 3);
        chk("t7_fa", 32'(fa7), 1);
        chk("t7_fq", 32'(fq7), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
